// File: rtl/rv32e_data_bus.sv
// rv32e_data_bus: CPU data-side bus with word RAM, UART TX FIFO/serialiser and cycle counter
module rv32e_data_bus #(
    parameter int RAM_WORDS    = 1024,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        tx_irq
);
    localparam int AW   = $clog2(RAM_WORDS);
    localparam int FW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = FW + 1;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic          ovf;
    logic [31:0]   cycles;
    state_t        state, state_d;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          pop;

    logic [AW-1:0] ram_idx;
    logic [28:0]   off;
    logic          tx_sel, sts_sel, cyc_sel, push, push_ok, full, empty, busy, bit_done;
    logic          unused_lo;

    assign unused_lo = ^addr[1:0];
    assign ram_idx   = addr[AW+1:2];
    assign off       = addr[30:2];
    assign tx_sel    = addr[31] && off == 29'd0;
    assign sts_sel   = addr[31] && off == 29'd1;
    assign cyc_sel   = addr[31] && off == 29'd2;
    assign full      = count == CNTW'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign busy      = state != IDLE;
    assign push      = we && tx_sel;
    assign push_ok   = push && !full;
    assign bit_done  = clk_cnt == CW'(CLKS_PER_BIT - 1);
    assign tx_irq    = empty && !busy;

    assign rdata = !addr[31] ? ram[ram_idx] :
                   sts_sel   ? {28'b0, ovf, busy, empty, full} :
                   cyc_sel   ? cycles : 32'h0;

    always_ff @(posedge clk)
        if (we && !addr[31]) ram[ram_idx] <= wdata;

    always_ff @(posedge clk)
        if (push_ok) fifo[wr_ptr] <= wdata[7:0];

    // a full FIFO drops the push even when a pop frees a slot in the same cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + FW'(1);
            if (pop) rd_ptr <= rd_ptr + FW'(1);
            count <= count + CNTW'(push_ok) - CNTW'(pop);
            ovf   <= (we && sts_sel) ? 1'b0 : (push && full) ? 1'b1 : ovf;
        end
    end

    always_ff @(posedge clk)
        cycles <= !reset ? 32'h0 : (we && cyc_sel) ? wdata : cycles + 32'd1;

    always_ff @(posedge clk)
        state <= !reset ? IDLE : state_d;

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            IDLE:    if (!empty) begin
                         state_d = START;
                         pop     = 1'b1;
                     end
            START:   if (bit_done) state_d = DATA;
            DATA:    if (bit_done && bit_idx == 3'd7) state_d = STOP;
            STOP:    if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // uart_tx is registered from the current state, so the line lags the FSM by one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            uart_tx <= 1'b1;
        end else begin
            clk_cnt <= (state == IDLE || bit_done) ? '0 : clk_cnt + CW'(1);
            if (pop) shreg <= fifo[rd_ptr];
            if (state == START) bit_idx <= '0;
            else if (state == DATA && bit_done) bit_idx <= bit_idx + 3'd1;
            uart_tx <= (state == START) ? 1'b0 : (state == DATA) ? shreg[bit_idx] : 1'b1;
        end
    end
endmodule

// File: tb/tb_rv32e_data_bus.sv
// tb_rv32e_data_bus: directed vectors and frame sequences for rv32e_data_bus
module tb_rv32e_data_bus;
    localparam logic [31:0] A_TX  = 32'h8000_0000;
    localparam logic [31:0] A_STS = 32'h8000_0004;
    localparam logic [31:0] A_CYC = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic [31:0] rdata;
    logic        uart_tx;
    logic        tx_irq;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[16];

    rv32e_data_bus #(.RAM_WORDS(1024), .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .uart_tx(uart_tx), .tx_irq(tx_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic expect_tx(input logic v, input string nm);
        @(posedge clk);
        #1;
        chk(nm, {31'b0, uart_tx}, {31'b0, v});
    endtask

    // frame sample c: 0-3 start, 4-35 data LSB first, 36-39 stop
    task automatic frame(input logic [7:0] b, input int from, input string nm);
        for (int c = from; c < 40; c++)
            expect_tx(c < 4 ? 1'b0 : c < 36 ? b[(c - 4) / 4] : 1'b1, $sformatf("%s_c%0d", nm, c));
    endtask

    task automatic wait_start(input logic [7:0] b, input string nm);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (uart_tx !== 1'b0 && n < 500);
        chk({nm, "_start"}, {31'b0, uart_tx}, 32'h0);
        frame(b, 1, nm);
    endtask

    initial begin
        logic [31:0] d;
        vt[0]  = '{32'h0000_0014, 32'h1234_5678, 1'b1, 32'h0};
        vt[1]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vt[2]  = '{32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[3]  = '{32'h0000_0013, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[4]  = '{32'h0000_0014, 32'h0,         1'b0, 32'h1234_5678};
        vt[5]  = '{32'h0000_1010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[6]  = '{32'h7FFF_F013, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[7]  = '{32'h8000_0010, 32'hCAFE_F00D, 1'b1, 32'h0};
        vt[8]  = '{32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[9]  = '{A_TX,          32'h0,         1'b0, 32'h0};
        vt[10] = '{A_STS,         32'h0,         1'b0, 32'h2};
        vt[11] = '{32'h8000_0010, 32'h0,         1'b0, 32'h0};
        vt[12] = '{A_CYC,         32'h100,       1'b1, 32'h0};
        vt[13] = '{A_CYC,         32'h0,         1'b0, 32'h100};
        vt[14] = '{32'h8000_000B, 32'h0,         1'b0, 32'h101};
        vt[15] = '{32'h8000_000C, 32'h0,         1'b0, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx", {31'b0, uart_tx}, 32'h1);
        chk("rst_irq", {31'b0, tx_irq}, 32'h1);
        rd(A_STS, d); chk("rst_status", d, 32'h2);
        rd(A_CYC, d); chk("rst_cycles", d, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            addr = vt[i].addr;
            wdata = vt[i].wdata;
            we = vt[i].we;
            #1;
            if (!vt[i].we) chk($sformatf("vec%0d", i), rdata, vt[i].exp);
            @(posedge clk);
            #1;
            we = 1'b0;
        end

        wr(A_CYC, 32'hFFFF_FFFE);
        rd(A_CYC, d); chk("cyc0", d, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        rd(A_CYC, d); chk("cyc1", d, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        rd(A_CYC, d); chk("cyc_wrap", d, 32'h0);

        wr(A_TX, 32'h55);
        chk("t2_push_edge", {31'b0, uart_tx}, 32'h1);
        expect_tx(1'b1, "t2_pop_edge");
        frame(8'h55, 0, "t2");
        chk("t2_irq_end", {31'b0, tx_irq}, 32'h1);

        wr(A_TX, 32'hA0);
        wr(A_TX, 32'h0F);
        chk("t4_pre", {31'b0, uart_tx}, 32'h1);
        frame(8'hA0, 0, "t4a");
        chk("t4_irq_mid", {31'b0, tx_irq}, 32'h0);
        expect_tx(1'b1, "t4_gap");
        frame(8'h0F, 0, "t4b");
        chk("t4_irq_end", {31'b0, tx_irq}, 32'h1);

        for (int b = 1; b <= 5; b++) wr(A_TX, b);
        rd(A_STS, d); chk("t3_full", d, 32'h5);
        wr(A_TX, 32'h6);
        rd(A_STS, d); chk("t3_ovf", d, 32'hD);
        wr(A_STS, 32'h0);
        rd(A_STS, d); chk("t3_ovf_clr", d, 32'h5);
        frame(8'h01, 5, "t3b1");
        for (int b = 2; b <= 5; b++) wait_start(b[7:0], $sformatf("t3b%0d", b));
        chk("t3_irq_end", {31'b0, tx_irq}, 32'h1);
        rd(A_STS, d); chk("t3_status_end", d, 32'h2);

        wr(A_TX, 32'h00);
        wr(A_TX, 32'h00);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_pre_tx", {31'b0, uart_tx}, 32'h0);
        rd(A_STS, d); chk("t6_pre_status", d, 32'h4);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("t6_tx", {31'b0, uart_tx}, 32'h1);
        rd(A_STS, d); chk("t6_status", d, 32'h2);
        rd(A_CYC, d); chk("t6_cycles", d, 32'h0);
        expect_tx(1'b1, "t6_idle");
        rd(32'h10, d); chk("t6_ram", d, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
